// File: rtl/strip_strike_tracker_if.sv
// strip_strike_tracker_if: request/response handshake between front-end, tracker and result logger.
interface strip_strike_tracker_if #(
  parameter int NUM_STRIPS = 4,
  parameter int WIDTH_BITS = 8
);
  localparam int IW = $clog2(NUM_STRIPS);
  logic                  req_valid;
  logic                  req_ready;
  logic [WIDTH_BITS-1:0] width_in;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [IW-1:0]         resp_strip_idx;
  logic                  resp_strike;
  logic [WIDTH_BITS:0]   resp_new_width;
  modport master (
    output req_valid, width_in, resp_ready,
    input  req_ready, resp_valid, resp_strip_idx, resp_strike, resp_new_width
  );
  modport slave (
    input  req_valid, width_in, resp_ready,
    output req_ready, resp_valid, resp_strip_idx, resp_strike, resp_new_width
  );
endinterface

// File: rtl/strip_strike_tracker.sv
// strip_strike_tracker: scans strips for least occupancy, places programs that fit, halts after repeated strikes.
module strip_strike_tracker #(
  parameter int NUM_STRIPS   = 4,
  parameter int WIDTH_BITS   = 8,
  parameter int STRIP_WIDTH  = 128,
  parameter int STRIKE_LIMIT = 3,
  localparam int IW = $clog2(NUM_STRIPS),
  localparam int SW = $clog2(STRIKE_LIMIT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  strip_strike_tracker_if.slave bus,
  output logic [SW-1:0]         strike_count,
  output logic                  halted,
  input  logic [IW-1:0]         occ_rd_idx,
  output logic [WIDTH_BITS-1:0] occ_rd_data
);
  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;
  state_t                state_q, state_d;
  logic [WIDTH_BITS-1:0] occ_q [NUM_STRIPS];
  logic [WIDTH_BITS-1:0] occ_d [NUM_STRIPS];
  logic [WIDTH_BITS-1:0] width_q, width_d, min_q, min_d;
  logic [IW-1:0]         idx_q, idx_d, min_idx_q, min_idx_d;
  logic [SW-1:0]         sc_q, sc_d;
  logic                  halted_q, halted_d;
  logic                  resp_valid_q, resp_valid_d, resp_strike_q, resp_strike_d;
  logic [IW-1:0]         resp_idx_q, resp_idx_d;
  logic [WIDTH_BITS:0]   resp_nw_q, resp_nw_d;
  logic [WIDTH_BITS-1:0] cur_occ, cand_min;
  logic [IW-1:0]         cand_idx;
  logic [WIDTH_BITS:0]   sum;
  logic                  take, last, strike;
  // strict less-than keeps the lowest index on ties
  assign cur_occ  = occ_q[idx_q];
  assign take     = idx_q == '0 || cur_occ < min_q;
  assign cand_min = take ? cur_occ : min_q;
  assign cand_idx = take ? idx_q : min_idx_q;
  assign sum      = {1'b0, cand_min} + {1'b0, width_q};
  assign strike   = sum > (WIDTH_BITS+1)'(STRIP_WIDTH);
  assign last     = idx_q == IW'(NUM_STRIPS - 1);
  always_comb begin
    state_d       = state_q;
    occ_d         = occ_q;
    width_d       = width_q;
    min_d         = min_q;
    idx_d         = idx_q;
    min_idx_d     = min_idx_q;
    sc_d          = sc_q;
    halted_d      = halted_q;
    resp_valid_d  = resp_valid_q;
    resp_strike_d = resp_strike_q;
    resp_idx_d    = resp_idx_q;
    resp_nw_d     = resp_nw_q;
    case (state_q)
      IDLE: if (bus.req_valid && bus.req_ready) begin
        width_d = bus.width_in;
        idx_d   = '0;
        state_d = SCAN;
      end
      SCAN: begin
        min_d     = cand_min;
        min_idx_d = cand_idx;
        idx_d     = idx_q + 1'b1;
        if (last) begin
          state_d       = RESP;
          resp_valid_d  = 1'b1;
          resp_idx_d    = cand_idx;
          resp_nw_d     = sum;
          resp_strike_d = strike;
          if (!strike) begin
            occ_d[cand_idx] = sum[WIDTH_BITS-1:0];
            sc_d            = '0;
          end else begin
            sc_d     = sc_q + 1'b1;
            halted_d = sc_d == SW'(STRIKE_LIMIT);
          end
        end
      end
      RESP: if (bus.resp_ready) begin
        resp_valid_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d       = IDLE;
      occ_d         = '{default: '0};
      idx_d         = '0;
      sc_d          = '0;
      halted_d      = 1'b0;
      resp_valid_d  = 1'b0;
      resp_strike_d = 1'b0;
      resp_idx_d    = '0;
      resp_nw_d     = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      occ_q         <= '{default: '0};
      width_q       <= '0;
      min_q         <= '0;
      idx_q         <= '0;
      min_idx_q     <= '0;
      sc_q          <= '0;
      halted_q      <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_strike_q <= 1'b0;
      resp_idx_q    <= '0;
      resp_nw_q     <= '0;
    end else begin
      state_q       <= state_d;
      occ_q         <= occ_d;
      width_q       <= width_d;
      min_q         <= min_d;
      idx_q         <= idx_d;
      min_idx_q     <= min_idx_d;
      sc_q          <= sc_d;
      halted_q      <= halted_d;
      resp_valid_q  <= resp_valid_d;
      resp_strike_q <= resp_strike_d;
      resp_idx_q    <= resp_idx_d;
      resp_nw_q     <= resp_nw_d;
    end
  end
  assign bus.req_ready      = state_q == IDLE && !halted_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_strip_idx = resp_idx_q;
  assign bus.resp_strike    = resp_strike_q;
  assign bus.resp_new_width = resp_nw_q;
  assign strike_count       = sc_q;
  assign halted             = halted_q;
  assign occ_rd_data        = occ_q[occ_rd_idx];
endmodule

// File: doc/strip_strike_tracker.md
Name: strip_strike_tracker

Overview:
Sequential, parametrised successor to the single-strip strike check. Holds the occupied width of NUM_STRIPS strips and accepts one program-width request per handshake. For each request it scans all strips for the least-occupied one and tests whether the program fits (a fit failure is a "strike"). On a fit it commits the placement; it also counts consecutive strikes and halts intake at a limit. Sits between the request front-end and the placement-result logger.

Parameters:
NUM_STRIPS, 4, number of strips tracked (≥2).
WIDTH_BITS, 8, width of program widths and occupancy values.
STRIP_WIDTH, 128, strip capacity; must be < 2^WIDTH_BITS.
STRIKE_LIMIT, 3, consecutive strikes that trigger halt (≥1).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
clear  in  1  synchronous clear of all state; highest priority after reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request.
width_in  in  WIDTH_BITS  program width.
resp_valid  out  1  result available.
resp_ready  in  1  consumer takes result.
resp_strip_idx  out  clog2(NUM_STRIPS)  chosen (min-occupancy) strip.
resp_strike  out  1  1 = did not fit, no placement made.
resp_new_width  out  WIDTH_BITS+1  min occupancy + width_in, unsaturated.
strike_count  out  clog2(STRIKE_LIMIT+1)  current consecutive strikes.
halted  out  1  strike limit reached; intake blocked.
occ_rd_idx  in  clog2(NUM_STRIPS)  debug occupancy read index.
occ_rd_data  out  WIDTH_BITS  combinational occupancy of strip occ_rd_idx.

Behaviour:
- Reset (rst_n low, async): all occupancies 0. FSM goes to IDLE. resp_valid=0, resp_strike=0, resp_strip_idx=0, resp_new_width=0, strike_count=0, halted=0. req_ready=1 once reset deasserts.
- FSM states:
  - IDLE: req_ready = !halted. On req_valid && req_ready, latch width_in, set scan index 0, go to SCAN.
  - SCAN: examines one strip per cycle, index 0..NUM_STRIPS-1. Tracks the running minimum; strict less-than compare, so on a tie the lowest index wins. After strip NUM_STRIPS-1, go to RESP.
  - RESP: resp_valid=1 with outputs held stable until resp_ready. On resp_ready, go to IDLE.
- Latency: resp_valid rises NUM_STRIPS cycles after the accepting edge. req_ready=0 in SCAN and RESP, so only one request is in flight.
- Arithmetic: sum = {0,min_occ} + {0,width_in}, computed at WIDTH_BITS+1 bits with no wrap. Strike iff sum > STRIP_WIDTH. Equality fits.
- Commit at the SCAN→RESP edge:
  - Fit: occupancy[min_idx] ← sum[WIDTH_BITS-1:0] and strike_count ← 0.
  - Strike: occupancy unchanged and strike_count increments; when it reaches STRIKE_LIMIT, halted ← 1.
- width_in = 0: normal fit to the min strip, occupancy unchanged, strike_count cleared.
- halted: sticky. req_ready=0 in IDLE; req_valid is ignored. Only clear or reset releases it.
- clear (sampled at clk edge, any state, including mid-SCAN or RESP with resp_ready low): applies the reset values above and returns to IDLE. The in-flight request is discarded with no response and no commit.
- No request is lost or duplicated under resp_ready backpressure.

Test Plan:
1. Reset then idle → occupancies all 0, req_ready=1, resp_valid=0, strike_count=0, halted=0.
2. Four requests of width 50 (defaults), resp_ready=1 → strips 0,1,2,3 in order (tie→lowest), resp_new_width=50, no strike. Fifth request of width 60 → strip 0, resp_new_width=110. Each resp_valid arrives exactly 4 cycles after acceptance.
3. Fill all strips to 100, request 29 → strip 0, resp_new_width=129, strike=1, occ[0] stays 100, strike_count=1. Then request 28 → strip 0, 128, strike=0, occ[0]=128, strike_count=0.
4. Overflow: occ all 100, width_in=200 → resp_new_width=300 (9-bit), strike=1, no wrap to 44.
5. Three consecutive strikes → halted=1, req_ready=0, further req_valid produces nothing. Pulse clear → halted=0, strike_count=0, occupancies 0, req_ready=1.
6. Hold resp_ready low for 5 cycles → outputs stable, req_ready=0. Then pulse clear during a SCAN → no resp_valid and occupancy unchanged (all 0).
